wb_dma_copier: RTL and testbench
================================

WB_DMA_COPIER -- requirements
Module: wb_dma_copier

Interface
REQ-001 SHALL have parameter LEN_W, default 16, the width of the word-count field.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for ack/err before aborting.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port wb, Wishbone.Controller, -, the bus initiator side, with the following signals.
  - wb.cyc and wb.stb: out, 1 each.
  - wb.we: out, 1.
  - wb.adr: out, 32.
  - wb.dat_w: out, 32.
  - wb.sel: out, 4.
  - wb.dat_r: in, 32.
  - wb.ack: in, 1.
  - wb.err: in, 1.
REQ-006 SHALL have port i_src_addr, input, 32, the source byte address; bits [1:0] are ignored and treated as 0.
REQ-007 SHALL have port i_dst_addr, input, 32, the destination byte address; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port i_len, input, LEN_W, the number of 32-bit words to copy.
REQ-009 SHALL have port i_start, input, 1, a one-cycle request; i_src_addr, i_dst_addr and i_len are sampled on that cycle.
REQ-010 SHALL have port o_busy, output, 1, high while a transfer is in progress.
REQ-011 SHALL have port o_done, output, 1, a one-cycle pulse when a transfer ends, whether it succeeded or failed.
REQ-012 SHALL have port o_err, output, 1, a sticky error flag for the last transfer.
REQ-013 SHALL have port o_count, output, LEN_W, the number of words fully written so far.

Function
REQ-014 SHALL implement the states IDLE, READ, WRITE and FINISH.
REQ-015 In IDLE, i_start SHALL latch its operands, clear o_count and o_err, and move the block to READ on the next cycle.
REQ-016 The first bus cycle SHALL begin exactly 1 clock after the i_start sample, with wb.cyc, wb.stb and o_busy all registered high.
REQ-017 If the latched length is 0, IDLE SHALL go directly to FINISH, with no bus activity and o_done one clock after i_start.
REQ-018 i_start SHALL be ignored whenever the block is not in IDLE; the latched operands SHALL not change.
REQ-019 Each READ bus cycle SHALL drive wb.we=0, wb.sel=4'hF and wb.adr=src+4*o_count.
REQ-020 Each WRITE bus cycle SHALL drive wb.we=1, wb.sel=4'hF, wb.adr=dst+4*o_count and wb.dat_w equal to the buffered read data.
REQ-021 The bus SHALL follow Wishbone classic cycles: wb.cyc, wb.stb, wb.adr, wb.we, wb.sel and wb.dat_w stay stable until the cycle in which wb.ack or wb.err is sampled high.
REQ-022 On a READ ack, the block SHALL capture wb.dat_r into a 32-bit buffer and assert WRITE stb on the next clock; wb.stb SHALL be low for exactly the ack cycle boundary.
REQ-023 On a WRITE ack, the block SHALL increment o_count. If o_count+1 equals the length it SHALL go to FINISH; otherwise it SHALL start the next READ on the following clock.
REQ-024 Address arithmetic SHALL be modulo 2^32; wrap-around past 0xFFFFFFFC continues at 0x00000000.
REQ-025 wb.cyc SHALL be deasserted in the cycle after each ack and re-asserted with stb; the bus is never locked across words.
REQ-026 If wb.err is high during an active cycle, the block SHALL set o_err, drop cyc and stb on the next clock, and go to FINISH; o_count is not incremented.
REQ-027 If wb.ack and wb.err are both high in the same cycle, the block SHALL treat it as err.
REQ-028 A cycle counter SHALL clear at each stb assertion. If the counter reaches TIMEOUT cycles without ack or err, the block SHALL abort exactly as in REQ-026.
REQ-029 FINISH SHALL last one cycle: o_done=1 and o_busy=0 in that cycle, then the block returns to IDLE. A new i_start SHALL be accepted from the FINISH cycle onward.
REQ-030 wb.ack or wb.err arriving while stb is low SHALL be ignored.

Reset
REQ-031 Assertion of i_rst_n=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and all of the following to zero: wb.cyc, wb.stb, wb.we, o_busy, o_done, o_err, o_count, wb.adr, wb.dat_w, wb.sel and the timeout counter.
REQ-032 Reset during a bus cycle SHALL abandon the transfer with no o_done; after reset release, the block SHALL wait for a fresh i_start.

Verification
REQ-033 Copy test: src=0x40000000, dst=0x40000100, len=4, responder ack latency 7. Required response: the 4 destination words equal the source words; o_done fires once; o_count=4; o_err=0; 8 bus cycles in strict R/W alternation.
REQ-034 Zero-length test: len=0. Required response: no wb.cyc ever; o_done high exactly one clock after i_start.
REQ-035 Error test: wb.err on the 2nd READ of len=5. Required response: o_err=1, o_count=1, o_done pulse; cyc low the next cycle.
REQ-036 Timeout test: responder never acks, TIMEOUT=255. Required response: stb is dropped after 255 cycles, o_err=1, o_done pulse.
REQ-037 Busy and wrap test: start with src=0xFFFFFFFC and len=2, and issue i_start again while busy. Required response: the second start is ignored; the read addresses are 0xFFFFFFFC then 0x00000000.
REQ-038 Reset test: assert i_rst_n low mid-WRITE. Required response: cyc, stb, o_busy and o_count are 0 before the next clock edge; no o_done.

Source files
------------

// File: rtl/wb_dma_copier_if.sv
// Wishbone classic bus bundle: 32-bit address/data, byte selects, ack/err termination.
interface Wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport Controller (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport Target (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_dma_copier.sv
// Word-by-word memory copier on a Wishbone classic bus: read one word, write it, repeat.
// Each bus cycle is bounded by a timeout; err or timeout aborts the whole transfer.
module wb_dma_copier #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  Wishbone.Controller      wb,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_count
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]       state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic [31:0]      rd_buf;
  logic [TMO_W-1:0] tmo;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [31:0]      adr;
  logic [31:0]      dat_w;
  logic [3:0]       sel;

  logic [LEN_W-1:0] count_inc;
  logic             tmo_hit;
  logic             bus_fault;
  logic             read_ack;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [LEN_W-1:0] idx);
    return base + (32'(idx) << 2);
  endfunction

  assign count_inc = o_count + 1'b1;
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
  // err wins over a simultaneous ack; a late ack on the last timeout cycle still counts
  assign bus_fault = stb && (wb.err || (!wb.ack && tmo_hit));
  assign read_ack  = (state == READ) && stb && wb.ack && !wb.err;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = we;
  assign wb.adr   = adr;
  assign wb.dat_w = dat_w;
  assign wb.sel   = sel;

  always_ff @(posedge i_clk) begin
    if (read_ack) rd_buf <= wb.dat_r;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      tmo     <= '0;
      cyc     <= 1'b0;
      stb     <= 1'b0;
      we      <= 1'b0;
      adr     <= '0;
      dat_w   <= '0;
      sel     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      o_count <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          if (i_start) begin
            src     <= i_src_addr & ~32'h3;
            dst     <= i_dst_addr & ~32'h3;
            len     <= i_len;
            o_count <= '0;
            o_err   <= 1'b0;
            if (i_len == '0) begin
              state  <= FINISH;
              o_done <= 1'b1;
            end else begin
              state  <= READ;
              o_busy <= 1'b1;
              cyc    <= 1'b1;
              stb    <= 1'b1;
              we     <= 1'b0;
              sel    <= 4'hF;
              adr    <= i_src_addr & ~32'h3;
              tmo    <= '0;
            end
          end
        end
        READ, WRITE: begin
          if (!stb) begin
            // idle gap after the previous ack: launch the next bus cycle
            cyc   <= 1'b1;
            stb   <= 1'b1;
            sel   <= 4'hF;
            tmo   <= '0;
            we    <= (state == WRITE);
            adr   <= (state == WRITE) ? word_addr(dst, o_count) : word_addr(src, o_count);
            dat_w <= rd_buf;
          end else if (bus_fault) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            o_err  <= 1'b1;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= FINISH;
          end else if (wb.ack) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            if (state == READ) begin
              state <= WRITE;
            end else begin
              o_count <= count_inc;
              if (count_inc == len) begin
                state  <= FINISH;
                o_done <= 1'b1;
                o_busy <= 1'b0;
              end else begin
                state <= READ;
              end
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_copier.sv
// Directed bench for wb_dma_copier: Wishbone responder with configurable latency/err/no-ack.
module tb_wb_dma_copier;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic             err_flag;
  logic [LEN_W-1:0] count;

  Wishbone wbi();

  wb_dma_copier #(.LEN_W(LEN_W), .TIMEOUT(255)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .wb        (wbi),
    .i_src_addr(src_addr),
    .i_dst_addr(dst_addr),
    .i_len     (len),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err_flag),
    .o_count   (count)
  );

  always #5 clk = ~clk;

  // responder modes: 0 normal ack, 1 err on read number err_on, 2 never respond
  int mode = 0;
  int lat = 0;
  int err_on = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic        we_log[$];
  int wait_cnt = 0;
  int n_reads = 0;
  int bus_cycles = 0;
  int stb_cycles = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_A5A5) + 32'h0101_0101;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : src_word(a);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      wbi.ack  = 1'b0;
      wbi.err  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wbi.ack || wbi.err) begin
        wbi.ack  = 1'b0;
        wbi.err  = 1'b0;
        wait_cnt = 0;
      end else if (wbi.cyc && wbi.stb) begin
        if (mode != 2 && wait_cnt == lat) begin
          bus_cycles++;
          we_log.push_back(wbi.we);
          if (!wbi.we) begin
            rd_log.push_back(wbi.adr);
            n_reads++;
            if (mode == 1 && n_reads == err_on) begin
              wbi.err = 1'b1;
            end else begin
              wbi.dat_r = mem_rd(wbi.adr);
              wbi.ack   = 1'b1;
            end
          end else begin
            mem[wbi.adr] = wbi.dat_w;
            wbi.ack = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (wbi.stb) stb_cycles++;
      if (wbi.cyc) cyc_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b_bus, b_done, b_we, b_rd, b_stb, b_cyc, n;
    logic alt_ok;
    logic [31:0] a0, a1;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(wbi.cyc), 32'd0);
    check_eq("rst_stb", 32'(wbi.stb), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err_flag), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // copy of 4 words, ack latency 7
    mode = 0; lat = 7;
    b_bus = bus_cycles; b_done = done_cnt; b_we = we_log.size();
    start_xfer(32'h4000_0000, 32'h4000_0100, 16'd4);
    check_eq("copy_first_cyc", 32'(wbi.cyc), 32'd1);
    check_eq("copy_first_stb", 32'(wbi.stb), 32'd1);
    check_eq("copy_first_busy", 32'(busy), 32'd1);
    check_eq("copy_first_adr", wbi.adr, 32'h4000_0000);
    check_eq("copy_first_we", 32'(wbi.we), 32'd0);
    wait_done(300, "copy_done");
    check_eq("copy_count", 32'(count), 32'd4);
    check_eq("copy_err", 32'(err_flag), 32'd0);
    check_eq("copy_busy_fin", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("copy_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("copy_bus_cycles", 32'(bus_cycles - b_bus), 32'd8);
    alt_ok = (we_log.size() == b_we + 8);
    if (alt_ok)
      for (int i = 0; i < 8; i++)
        if (we_log[b_we + i] != i[0]) alt_ok = 1'b0;
    check_eq("copy_alternation", 32'(alt_ok), 32'd1);
    for (int i = 0; i < 4; i++)
      check_eq("copy_dst_word", mem_rd(32'h4000_0100 + 32'(4 * i)), src_word(32'h4000_0000 + 32'(4 * i)));

    // zero length: no bus activity, done one clock after start
    b_cyc = cyc_cnt; b_done = done_cnt;
    start_xfer(32'h4000_0000, 32'h4000_0800, 16'd0);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("zero_done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("zero_no_cyc", 32'(cyc_cnt - b_cyc), 32'd0);
    check_eq("zero_done_cnt", 32'(done_cnt - b_done), 32'd1);

    // err on the second read of a 5-word copy
    mode = 1; lat = 2; err_on = n_reads + 2;
    start_xfer(32'h4000_0000, 32'h4000_0200, 16'd5);
    wait_done(200, "err_done");
    check_eq("err_cyc_low", 32'(wbi.cyc), 32'd0);
    check_eq("err_stb_low", 32'(wbi.stb), 32'd0);
    check_eq("err_flag", 32'(err_flag), 32'd1);
    check_eq("err_count", 32'(count), 32'd1);
    check_eq("err_dst0", mem_rd(32'h4000_0200), src_word(32'h4000_0000));
    check_eq("err_dst1_unwritten", 32'(mem.exists(32'h4000_0204)), 32'd0);
    repeat (2) @(negedge clk);

    // responder never answers: stb held 255 cycles, then abort
    mode = 2;
    b_stb = stb_cycles; b_done = done_cnt;
    start_xfer(32'h4000_0000, 32'h4000_0300, 16'd1);
    wait_done(400, "tmo_done");
    check_eq("tmo_err", 32'(err_flag), 32'd1);
    check_eq("tmo_stb_low", 32'(wbi.stb), 32'd0);
    check_eq("tmo_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("tmo_stb_cycles", 32'(stb_cycles - b_stb), 32'd255);
    check_eq("tmo_done_cnt", 32'(done_cnt - b_done), 32'd1);

    // address wrap, low address bits ignored, second start while busy ignored
    mode = 0; lat = 3;
    b_rd = rd_log.size(); b_bus = bus_cycles; b_done = done_cnt;
    start_xfer(32'hFFFF_FFFC, 32'h0000_0303, 16'd2);
    repeat (2) @(negedge clk);
    start_xfer(32'h0000_0500, 32'h0000_0600, 16'd7);
    wait_done(200, "wrap_done");
    check_eq("wrap_count", 32'(count), 32'd2);
    check_eq("wrap_err", 32'(err_flag), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    a0 = (rd_log.size() > b_rd) ? rd_log[b_rd] : 32'hDEAD_BEEF;
    a1 = (rd_log.size() > b_rd + 1) ? rd_log[b_rd + 1] : 32'hDEAD_BEEF;
    check_eq("wrap_rd_n", 32'(rd_log.size() - b_rd), 32'd2);
    check_eq("wrap_rd_adr0", a0, 32'hFFFF_FFFC);
    check_eq("wrap_rd_adr1", a1, 32'h0000_0000);
    check_eq("wrap_dst0", mem_rd(32'h0000_0300), src_word(32'hFFFF_FFFC));
    check_eq("wrap_dst1", mem_rd(32'h0000_0304), src_word(32'h0000_0000));
    check_eq("wrap_second_ignored", 32'(mem.exists(32'h0000_0600)), 32'd0);
    check_eq("wrap_done_cnt", 32'(done_cnt - b_done), 32'd1);

    // asynchronous reset during the second WRITE cycle
    mode = 0; lat = 4;
    b_done = done_cnt;
    start_xfer(32'h4000_0000, 32'h4000_0400, 16'd3);
    n = 0;
    while (!(wbi.stb && wbi.we && count == 16'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstw_in_write", 32'(wbi.stb && wbi.we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_cyc", 32'(wbi.cyc), 32'd0);
    check_eq("rstw_stb", 32'(wbi.stb), 32'd0);
    check_eq("rstw_busy", 32'(busy), 32'd0);
    check_eq("rstw_count", 32'(count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_cyc = cyc_cnt;
    repeat (6) @(negedge clk);
    #1;
    check_eq("rstw_no_done", 32'(done_cnt - b_done), 32'd0);
    check_eq("rstw_stays_idle", 32'(cyc_cnt - b_cyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
